// File: rtl/uart_tx_engine.sv
// UART transmit engine: byte FIFO feeding an 8N1 serializer with a programmable baud divisor.
// Status outputs (count/full/empty/busy/overflow) are registered and reflect the edge just taken.
module uart_tx_engine #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned DEFAULT_DIV = 434
) (
  input  logic                   clk,
  input  logic                   nReset,
  input  logic [31:0]            bus_wdata,
  input  logic                   tx_wen,
  input  logic                   baud_wen,
  input  logic                   ovf_clr,
  output logic                   tx,
  output logic                   tx_busy,
  output logic                   tx_full,
  output logic                   tx_empty,
  output logic [$clog2(DEPTH):0] tx_count,
  output logic                   tx_overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]       state, state_n;
  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] div_act, div_act_n;
  logic [DIV_W-1:0] bit_cnt, bit_cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shift, shift_n;
  logic             tx_n;
  logic             pop_c, push_c, ovf_evt_c;
  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count_n;
  logic             unused_bits;

  assign unused_bits = ^bus_wdata[31:DIV_W];

  // Next-state, next-output and FIFO pop decision for the serializer
  always_comb begin
    state_n   = state;
    div_act_n = div_act;
    bit_cnt_n = bit_cnt;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    tx_n      = tx;
    pop_c     = 1'b0;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (!tx_empty) begin
          pop_c     = 1'b1;
          shift_n   = mem[rd_ptr];
          div_act_n = div_reg;
          bit_cnt_n = div_reg - DIV_W'(1);
          state_n   = START;
          tx_n      = 1'b0;
        end
      end
      START: begin
        if (bit_cnt == '0) begin
          state_n   = DATA;
          bit_idx_n = 3'd0;
          bit_cnt_n = div_act - DIV_W'(1);
          tx_n      = shift[0];
        end else begin
          bit_cnt_n = bit_cnt - DIV_W'(1);
        end
      end
      DATA: begin
        if (bit_cnt == '0) begin
          bit_cnt_n = div_act - DIV_W'(1);
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            shift_n   = {1'b0, shift[7:1]};
            bit_idx_n = bit_idx + 3'd1;
            tx_n      = shift[1];
          end
        end else begin
          bit_cnt_n = bit_cnt - DIV_W'(1);
        end
      end
      STOP: begin
        tx_n = 1'b1;
        if (bit_cnt == '0) begin
          // Chain straight into the next frame when a byte is waiting
          if (!tx_empty) begin
            pop_c     = 1'b1;
            shift_n   = mem[rd_ptr];
            div_act_n = div_reg;
            bit_cnt_n = div_reg - DIV_W'(1);
            state_n   = START;
            tx_n      = 1'b0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          bit_cnt_n = bit_cnt - DIV_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  // A full FIFO still accepts a push when the serializer pops in the same cycle
  assign push_c    = tx_wen && (!tx_full || pop_c);
  assign ovf_evt_c = tx_wen && tx_full && !pop_c;

  always_comb begin
    count_n = tx_count;
    if (push_c && !pop_c)
      count_n = tx_count + CNT_W'(1);
    else if (pop_c && !push_c)
      count_n = tx_count - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (nReset) begin
      state       <= IDLE;
      div_act     <= DIV_W'(DEFAULT_DIV);
      bit_cnt     <= '0;
      bit_idx     <= 3'd0;
      shift       <= 8'd0;
      tx          <= 1'b1;
      tx_busy     <= 1'b0;
      div_reg     <= DIV_W'(DEFAULT_DIV);
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      tx_count    <= '0;
      tx_full     <= 1'b0;
      tx_empty    <= 1'b1;
      tx_overflow <= 1'b0;
    end else begin
      state    <= state_n;
      div_act  <= div_act_n;
      bit_cnt  <= bit_cnt_n;
      bit_idx  <= bit_idx_n;
      shift    <= shift_n;
      tx       <= tx_n;
      tx_busy  <= (state_n != IDLE);
      if (push_c)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)
        rd_ptr <= rd_ptr + PTR_W'(1);
      tx_count <= count_n;
      tx_full  <= (count_n == CNT_W'(DEPTH));
      tx_empty <= (count_n == '0);
      if (ovf_evt_c)
        tx_overflow <= 1'b1;
      else if (ovf_clr)
        tx_overflow <= 1'b0;
      // Divisors below 4 are rejected and the previous value is kept
      if (baud_wen && (bus_wdata[DIV_W-1:0] >= DIV_W'(4)))
        div_reg <= bus_wdata[DIV_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (push_c)
      mem[wr_ptr] <= bus_wdata[7:0];
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: timeline model predicts frames and status, a line monitor decodes tx.
module tb_uart_tx_engine;

  localparam int DEPTH       = 8;
  localparam int DIV_W       = 16;
  localparam int DEFAULT_DIV = 434;

  logic        clk = 1'b0;
  logic        nReset;
  logic [31:0] bus_wdata;
  logic        tx_wen, baud_wen, ovf_clr;
  logic        tx, tx_busy, tx_full, tx_empty, tx_overflow;
  logic [$clog2(DEPTH):0] tx_count;

  uart_tx_engine #(.DEPTH(DEPTH), .DIV_W(DIV_W), .DEFAULT_DIV(DEFAULT_DIV)) dut (
    .clk(clk), .nReset(nReset), .bus_wdata(bus_wdata), .tx_wen(tx_wen),
    .baud_wen(baud_wen), .ovf_clr(ovf_clr), .tx(tx), .tx_busy(tx_busy),
    .tx_full(tx_full), .tx_empty(tx_empty), .tx_count(tx_count),
    .tx_overflow(tx_overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model state: bytes waiting, frames promised to the line, current divisor
  byte unsigned q_b[$];
  int           q_e[$];
  byte unsigned sb_b[$];
  int           sb_d[$];
  int           sb_e[$];
  int           m_div = DEFAULT_DIV;
  int           line_free_at = 0;
  bit           m_ovf = 1'b0;
  bit           rst_seen = 1'b0;

  bit           in_frame = 1'b0;
  int           k, f_div, f_byte;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference timeline: a frame starts when a byte waits and the line is free, lasting 10*div
  initial forever begin : model
    int  n;
    int  div_pre;
    bit  dropped;
    @(posedge clk);
    cyc++;
    n = cyc;
    if (nReset) begin
      q_b.delete(); q_e.delete();
      sb_b.delete(); sb_d.delete(); sb_e.delete();
      m_div = DEFAULT_DIV;
      line_free_at = 0;
      m_ovf = 1'b0;
      rst_seen = 1'b1;
    end else begin
      div_pre = m_div;
      dropped = 1'b0;
      if (q_b.size() > 0 && n >= line_free_at && q_e[0] < n) begin
        sb_b.push_back(q_b.pop_front());
        void'(q_e.pop_front());
        sb_d.push_back(div_pre);
        sb_e.push_back(n);
        line_free_at = n + 10 * div_pre;
      end
      if (tx_wen) begin
        if (q_b.size() < DEPTH) begin
          q_b.push_back(bus_wdata[7:0]);
          q_e.push_back(n);
        end else begin
          dropped = 1'b1;
        end
      end
      if (dropped) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      if (baud_wen && bus_wdata[15:0] >= 16'd4) m_div = int'(bus_wdata[15:0]);
    end
  end

  // Monitor: status every cycle, and decode each frame seen on tx against the scoreboard
  initial forever begin : monitor
    int slot;
    int expbit;
    @(negedge clk);
    if (rst_seen) begin
      in_frame = 1'b0;
      rst_seen = 1'b0;
    end
    chk("tx_count", tx_count, q_b.size());
    chk("tx_full", tx_full, (q_b.size() == DEPTH) ? 1 : 0);
    chk("tx_empty", tx_empty, (q_b.size() == 0) ? 1 : 0);
    chk("tx_busy", tx_busy, (cyc < line_free_at) ? 1 : 0);
    chk("tx_overflow", tx_overflow, m_ovf);
    if (!in_frame && tx == 1'b0) begin
      chk("frame_expected", sb_b.size(), (sb_b.size() > 0) ? sb_b.size() : 1);
      if (sb_b.size() > 0) begin
        f_byte = sb_b.pop_front();
        f_div  = sb_d.pop_front();
        chk("start_cycle", cyc, sb_e.pop_front());
        in_frame = 1'b1;
        k = 0;
      end
    end
    if (in_frame) begin
      slot = k / f_div;
      if (slot == 0) expbit = 0;
      else if (slot <= 8) expbit = (f_byte >> (slot - 1)) & 1;
      else expbit = 1;
      chk("tx_bit", tx, expbit);
      k++;
      if (k == 10 * f_div) in_frame = 1'b0;
    end else if (tx != 1'b0) begin
      chk("tx_idle", tx, 1);
    end
  end

  task automatic drive(input bit w, input bit b, input bit c, input logic [31:0] d);
    tx_wen = w; baud_wen = b; ovf_clr = c; bus_wdata = d;
    @(posedge clk); #1;
    tx_wen = 1'b0; baud_wen = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input int max);
    int i;
    i = 0;
    while ((q_b.size() > 0 || cyc < line_free_at || in_frame) && i < max) begin
      @(posedge clk);
      i++;
    end
    #1;
    idle(3);
    chk("drain_done", (q_b.size() == 0 && !in_frame && sb_b.size() == 0) ? 1 : 0, 1);
  endtask

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    nReset = 1'b1; tx_wen = 1'b0; baud_wen = 1'b0; ovf_clr = 1'b0; bus_wdata = '0;
    idle(3);
    nReset = 1'b0;
    idle(20);
    chk("reset_tx", tx, 1);
    chk("reset_empty", tx_empty, 1);

    drive(0, 1, 0, 32'd4);
    drive(1, 0, 0, 32'hA5);
    drain(200);

    for (int i = 0; i < 10; i++) drive(1, 0, 0, 32'(i));
    chk("burst_overflow", tx_overflow, 1);
    chk("burst_full", tx_full, 1);
    drain(1000);
    drive(0, 0, 1, 32'd0);
    chk("ovf_cleared", tx_overflow, 0);

    drive(1, 0, 0, 32'h3C);
    drive(1, 0, 0, 32'h55);
    idle(14);
    drive(0, 1, 0, 32'd8);
    drain(500);

    drive(0, 1, 0, 32'd2);
    drive(0, 1, 0, 32'd0);
    drive(1, 0, 0, 32'h77);
    drain(500);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] d;
      bit w, b, c;
      w = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 15) == 0);
      c = ($urandom_range(0, 7) == 0);
      d = $urandom;
      if (b) d[15:0] = 16'($urandom_range(0, 9));
      drive(w, b, c, d);
    end
    drain(3000);

    drive(0, 1, 0, 32'd4);
    for (int i = 0; i < 4; i++) drive(1, 0, 0, 32'hA1 + 32'(i));
    idle(14);
    nReset = 1'b1;
    idle(1);
    nReset = 1'b0;
    chk("abort_tx", tx, 1);
    chk("abort_busy", tx_busy, 0);
    chk("abort_count", tx_count, 0);
    drive(1, 0, 0, 32'h96);
    drain(6000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
